// File: rtl/branch_stack_pkg.sv
// Shared types for the branch-ID / checkpoint stack and the machine-wide
// branch resolution broadcast.
package branch_stack_pkg;

  localparam int NUM_BR = 4;
  localparam int ADDR_W = 32;

  typedef logic [NUM_BR-1:0] br_mask_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    NOTHING = 2'd0,
    CLEAR   = 2'd1,
    SQUASH  = 2'd2
  } br_task_e;

endpackage

// File: rtl/branch_stack_br_id_picker.sv
// Lowest-free one-hot priority encoder over the outstanding-branch mask.
module br_id_picker
  import branch_stack_pkg::*;
#(
  parameter int NUM_BR = 4
) (
  input  br_mask_t valid,
  output br_mask_t alloc_b_id,
  output logic     alloc_ready
);

  logic found;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path through the block can infer a latch.
  always_comb begin
    alloc_b_id = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (!valid[i] && !found) begin
        alloc_b_id[i] = 1'b1;
        found         = 1'b1;
      end
    end
    alloc_ready = found;
  end

endmodule

// File: rtl/branch_stack.sv
// Dispatch-side branch ID allocator and checkpoint store; turns branch FU
// resolutions into the registered squash/clear broadcast.
module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int NUM_BR   = 4,
  parameter int CP_WIDTH = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic [CP_WIDTH-1:0] alloc_cp,
  output logic                alloc_ready,
  output br_mask_t            alloc_b_id,
  output br_mask_t            cur_b_mask,
  input  br_task_e            br_task,
  input  br_mask_t            br_b_id,
  input  addr_t               br_target,
  output br_task_e            rem_br_task,
  output br_mask_t            rem_b_id,
  output addr_t               rem_target,
  output logic [CP_WIDTH-1:0] rem_cp
);

  br_mask_t            cur_b_mask_q, cur_b_mask_d;
  br_mask_t            dep_mask_q [NUM_BR];
  br_mask_t            dep_mask_d [NUM_BR];
  logic [CP_WIDTH-1:0] cp_q [NUM_BR];
  logic [CP_WIDTH-1:0] cp_d [NUM_BR];
  br_task_e            rem_br_task_q, rem_br_task_d;
  br_mask_t            rem_b_id_q, rem_b_id_d;
  addr_t               rem_target_q, rem_target_d;
  logic [CP_WIDTH-1:0] rem_cp_q, rem_cp_d;

  logic                accept, clear_fire, squash_fire, grant;
  br_mask_t            free_mask;
  logic [CP_WIDTH-1:0] sel_cp;

  br_id_picker #(.NUM_BR(NUM_BR)) u_picker (
    .valid       (cur_b_mask_q),
    .alloc_b_id  (alloc_b_id),
    .alloc_ready (alloc_ready)
  );

  always_comb begin
    accept      = (br_task != NOTHING) && ((br_b_id & cur_b_mask_q) != '0);
    clear_fire  = accept && (br_task == CLEAR);
    squash_fire = accept && (br_task == SQUASH);
    // A squash kills any same-cycle dispatch: that branch is younger.
    grant       = alloc_en && alloc_ready && !squash_fire;

    free_mask = accept ? br_b_id : '0;
    sel_cp    = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (squash_fire && cur_b_mask_q[i] && ((dep_mask_q[i] & br_b_id) != '0))
        free_mask[i] = 1'b1;
      if (br_b_id[i])
        sel_cp = sel_cp | cp_q[i];
    end

    cur_b_mask_d = (cur_b_mask_q & ~free_mask) | (grant ? alloc_b_id : '0);
    cp_d         = cp_q;
    for (int i = 0; i < NUM_BR; i++) begin
      dep_mask_d[i] = dep_mask_q[i] & ~free_mask;
      if (grant && alloc_b_id[i]) begin
        dep_mask_d[i] = cur_b_mask_q & ~free_mask;
        cp_d[i]       = alloc_cp;
      end
    end

    rem_br_task_d = accept ? br_task : NOTHING;
    rem_b_id_d    = accept ? br_b_id : '0;
    rem_target_d  = squash_fire ? br_target : '0;
    rem_cp_d      = squash_fire ? sel_cp : '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_b_mask_q  <= '0;
      rem_br_task_q <= NOTHING;
      rem_b_id_q    <= '0;
      rem_target_q  <= '0;
      rem_cp_q      <= '0;
      for (int i = 0; i < NUM_BR; i++) dep_mask_q[i] <= '0;
    end else begin
      cur_b_mask_q  <= cur_b_mask_d;
      rem_br_task_q <= rem_br_task_d;
      rem_b_id_q    <= rem_b_id_d;
      rem_target_q  <= rem_target_d;
      rem_cp_q      <= rem_cp_d;
      dep_mask_q    <= dep_mask_d;
    end
  end

  // NOTE: checkpoint storage is not reset; an entry's cp is only read while
  // its valid bit is set, and that bit is cleared by reset.
  always_ff @(posedge clock) begin
    cp_q <= cp_d;
  end

  assign cur_b_mask  = cur_b_mask_q;
  assign rem_br_task = rem_br_task_q;
  assign rem_b_id    = rem_b_id_q;
  assign rem_target  = rem_target_q;
  assign rem_cp      = rem_cp_q;

  a_br_id_onehot0 : assert property (@(posedge clock) disable iff (reset)
    $onehot0(br_b_id));

  a_no_alloc_of_accepted : assert property (@(posedge clock) disable iff (reset)
    !(accept && grant && ((br_b_id & alloc_b_id) != '0)));

endmodule

// File: tb/tb_branch_stack.sv
// Scoreboard bench for branch_stack: a behavioural model queues the expected
// broadcast and mask for each driven cycle, popped one edge later.
module tb_branch_stack;
  import branch_stack_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_en = 1'b0;
  logic [63:0] alloc_cp = '0;
  logic        alloc_ready;
  br_mask_t    alloc_b_id, cur_b_mask;
  br_task_e    br_task = NOTHING;
  br_mask_t    br_b_id = '0;
  addr_t       br_target = '0;
  br_task_e    rem_br_task;
  br_mask_t    rem_b_id;
  addr_t       rem_target;
  logic [63:0] rem_cp;

  branch_stack #(.NUM_BR(4), .CP_WIDTH(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_cp    (alloc_cp),
    .alloc_ready (alloc_ready),
    .alloc_b_id  (alloc_b_id),
    .cur_b_mask  (cur_b_mask),
    .br_task     (br_task),
    .br_b_id     (br_b_id),
    .br_target   (br_target),
    .rem_br_task (rem_br_task),
    .rem_b_id    (rem_b_id),
    .rem_target  (rem_target),
    .rem_cp      (rem_cp)
  );

  always #5 clock = ~clock;

  typedef struct {
    br_task_e    rtask;
    br_mask_t    bid;
    addr_t       target;
    logic [63:0] cp;
    br_mask_t    mask;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;

  br_mask_t    m_valid;
  br_mask_t    m_dep [4];
  logic [63:0] m_cp  [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = '0;
    for (int i = 0; i < 4; i++) begin
      m_dep[i] = '0;
      m_cp[i]  = '0;
    end
    sb_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Called at posedge+1: drives one cycle, checks combinational outputs,
  // queues the expectation, then compares after the next edge.
  task automatic drive(input logic a_en, input logic [63:0] a_cp, input br_task_e t,
                       input br_mask_t bid, input addr_t tgt);
    logic     acc, sq, grant_m;
    br_mask_t freem, lowest, old_valid;
    int       k;
    exp_t     e, got;
    alloc_en  = a_en;
    alloc_cp  = a_cp;
    br_task   = t;
    br_b_id   = bid;
    br_target = tgt;
    #1;
    lowest = '0;
    k      = -1;
    for (int i = 0; i < 4; i++)
      if (!m_valid[i] && k < 0) begin
        k         = i;
        lowest[i] = 1'b1;
      end
    check("alloc_ready", 64'(alloc_ready), 64'(m_valid != 4'hF));
    check("alloc_b_id", 64'(alloc_b_id), 64'(lowest));

    acc   = (t != NOTHING) && ((bid & m_valid) != '0);
    sq    = acc && (t == SQUASH);
    freem = acc ? bid : '0;
    e.cp  = '0;
    for (int i = 0; i < 4; i++) begin
      if (sq && m_valid[i] && ((m_dep[i] & bid) != '0)) freem[i] = 1'b1;
      if (sq && bid[i]) e.cp = m_cp[i];
    end
    grant_m  = a_en && (k >= 0) && !sq;
    e.rtask  = acc ? t : NOTHING;
    e.bid    = acc ? bid : '0;
    e.target = sq ? tgt : '0;

    old_valid = m_valid;
    m_valid   = m_valid & ~freem;
    for (int i = 0; i < 4; i++) m_dep[i] = m_dep[i] & ~freem;
    if (grant_m) begin
      m_valid[k] = 1'b1;
      m_dep[k]   = old_valid & ~freem;
      m_cp[k]    = a_cp;
    end
    e.mask = m_valid;
    sb_q.push_back(e);

    @(posedge clock);
    #1;
    alloc_en = 1'b0;
    br_task  = NOTHING;
    br_b_id  = '0;
    got = sb_q.pop_front();
    check("rem_br_task", 64'(rem_br_task), 64'(got.rtask));
    check("rem_b_id", 64'(rem_b_id), 64'(got.bid));
    check("rem_target", 64'(rem_target), 64'(got.target));
    check("rem_cp", rem_cp, got.cp);
    check("cur_b_mask", 64'(cur_b_mask), 64'(got.mask));
  endtask

  task automatic alloc4();
    for (int i = 0; i < 4; i++) drive(1'b1, 64'hAA + 64'(i), NOTHING, '0, '0);
  endtask

  initial begin
    br_task_e t;
    br_mask_t b;
    model_clear();
    do_reset();
    check("reset_mask", 64'(cur_b_mask), 64'h0);
    check("reset_task", 64'(rem_br_task), 64'(NOTHING));
    check("reset_ready", 64'(alloc_ready), 64'h1);
    check("reset_bid", 64'(alloc_b_id), 64'h1);

    // Fill, overflow attempt, clear one, reallocate it.
    alloc4();
    check("full_mask", 64'(cur_b_mask), 64'hF);
    check("full_ready", 64'(alloc_ready), 64'h0);
    check("full_bid", 64'(alloc_b_id), 64'h0);
    drive(1'b1, 64'h55, NOTHING, '0, '0);
    drive(1'b0, '0, CLEAR, 4'b0010, '0);
    check("clear_task", 64'(rem_br_task), 64'(CLEAR));
    check("clear_mask", 64'(cur_b_mask), 64'hD);
    drive(1'b1, 64'h77, NOTHING, '0, '0);
    check("realloc_mask", 64'(cur_b_mask), 64'hF);
    drive(1'b0, '0, SQUASH, 4'b0100, 32'h40);
    check("sq_young_mask", 64'(cur_b_mask), 64'h1);

    // Squash in a dependency chain, pulse width, stale resolution.
    do_reset();
    alloc4();
    drive(1'b0, '0, SQUASH, 4'b0010, 32'h100);
    check("sq_task", 64'(rem_br_task), 64'(SQUASH));
    check("sq_target", 64'(rem_target), 64'h100);
    check("sq_cp", rem_cp, 64'hAB);
    check("sq_mask", 64'(cur_b_mask), 64'h1);
    drive(1'b0, '0, NOTHING, '0, '0);
    check("pulse_end", 64'(rem_br_task), 64'(NOTHING));
    drive(1'b0, '0, SQUASH, 4'b0100, 32'h200);
    check("stale_task", 64'(rem_br_task), 64'(NOTHING));
    check("stale_mask", 64'(cur_b_mask), 64'h1);

    // Squash with a same-cycle allocation: the allocation is dropped.
    drive(1'b1, 64'h99, SQUASH, 4'b0001, 32'h300);
    check("kill_mask", 64'(cur_b_mask), 64'h0);
    check("kill_cp", rem_cp, 64'hAA);
    drive(1'b0, '0, NOTHING, '0, '0);

    // Reset while a squash broadcast is on the outputs.
    drive(1'b1, 64'h11, NOTHING, '0, '0);
    drive(1'b1, 64'h22, NOTHING, '0, '0);
    drive(1'b0, '0, SQUASH, 4'b0001, 32'h400);
    check("pre_rst_task", 64'(rem_br_task), 64'(SQUASH));
    reset = 1'b1;
    #1;
    check("async_rst_task", 64'(rem_br_task), 64'(NOTHING));
    check("async_rst_mask", 64'(cur_b_mask), 64'h0);
    check("async_rst_tgt", 64'(rem_target), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();

    // Random traffic against the model, including stale ids.
    for (int n = 0; n < 300; n++) begin
      t = br_task_e'($urandom_range(0, 2));
      b = (t == NOTHING) ? br_mask_t'(0) : br_mask_t'(4'b0001 << $urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, t, b, addr_t'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_stack.md
Name: branch_stack

Overview:
- Dispatch-side owner of branch IDs and checkpoints; consumes the CLEAR/SQUASH resolution emitted by the branch FU.
- Allocates one-hot b_ids to dispatching branches, tracks the outstanding branch mask, and stores a checkpoint per in-flight branch.
- Converts a resolution into the registered machine-wide broadcast (rem_br_task/rem_b_id) plus recovery data; that broadcast drives squash and mask-clear in every FU, RS and ROB.

Parameters:
- NUM_BR, 4, in-flight branch entries; must equal the width of the package BR_MASK type.
- CP_WIDTH, 64, width of the opaque recovery checkpoint (map-table / free-list / ROB-tail snapshot tag).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alloc_en  in  1  dispatch presents a branch this cycle
- alloc_cp  in  CP_WIDTH  checkpoint captured with the branch
- alloc_ready  out  1  a free entry exists (combinational)
- alloc_b_id  out  BR_MASK  one-hot id granted: lowest free index, combinational
- cur_b_mask  out  BR_MASK  registered mask of outstanding branches; dispatch tags every instruction with it
- br_task  in  BR_TASK  resolution from the branch FU: NOTHING/CLEAR/SQUASH
- br_b_id  in  BR_MASK  one-hot id of the resolving branch
- br_target  in  ADDR  corrected next PC; meaningful on SQUASH
- rem_br_task  out  BR_TASK  broadcast task, registered
- rem_b_id  out  BR_MASK  broadcast id, registered
- rem_target  out  ADDR  redirect PC, valid with SQUASH
- rem_cp  out  CP_WIDTH  checkpoint of the squashed branch, valid with SQUASH

Behaviour:
- Per-entry state: valid, dep_mask[NUM_BR] (older branches outstanding at allocation), cp.
- Reset, asynchronous: all valid=0, dep_masks=0, cur_b_mask=0, rem_br_task=NOTHING, rem_b_id=0, rem_target=0, rem_cp=0.
- Allocation:
  - grant = alloc_en & alloc_ready & ~kill.
  - On grant at edge: entry[alloc_b_id].valid=1, dep_mask = cur_b_mask with the cleared bit removed (same-cycle CLEAR), cp = alloc_cp, and cur_b_mask gains alloc_b_id.
- Resolution is accepted only if br_task!=NOTHING and entry[br_b_id].valid. Otherwise it is ignored: no broadcast, no state change.
- CLEAR of id b, at the edge:
  - entry b freed, bit b removed from cur_b_mask and from every dep_mask.
  - Next cycle: rem_br_task=CLEAR, rem_b_id=b; rem_target and rem_cp are 0.
- SQUASH of id b, at the edge:
  - entry b and every entry with dep_mask[b]=1 freed; those bits removed from cur_b_mask.
  - Next cycle: rem_br_task=SQUASH, rem_b_id=b, rem_target=br_target, rem_cp=entry[b].cp.
- kill = accepted SQUASH this cycle. An allocation in the same cycle is dropped: that instruction is younger and is squashed. Dispatch observes this via the squash broadcast, not via alloc_ready.
- Latency: one cycle from br_task to rem_*. Broadcast pulses exactly one cycle, then returns to NOTHING/0.
- A freed id is reallocatable from the cycle after the freeing edge, never in the same cycle.
- Full (all valid): alloc_ready=0, alloc_b_id=0; alloc_en is ignored.
- Stale resolution: a branch already freed by an earlier squash resolves late; it is ignored silently.
- Reset mid-broadcast: rem_* return to NOTHING/0 immediately.
- Assertions:
  - br_b_id is one-hot or zero.
  - an accepted id is never also being allocated.

Decomposition:
- Package, alongside the existing types: BR_TASK (NOTHING/CLEAR/SQUASH), BR_MASK, NUM_BR constant, ADDR.
- One sub-module, br_id_picker: lowest-free one-hot priority encoder over ~valid, producing alloc_b_id and alloc_ready.

Test Plan:
- Reset, then four allocs on consecutive cycles -> b_ids 0001, 0010, 0100, 1000; cur_b_mask=1111; alloc_ready=0; a fifth alloc_en is ignored.
- With all four outstanding, br_task=CLEAR, br_b_id=0010 -> next cycle rem_br_task=CLEAR, rem_b_id=0010, cur_b_mask=1101; the next alloc gets 0010 with dep_mask excluding bit 1.
- Four outstanding (dep chain 0→1→2→3), SQUASH of 0010 with br_target=0x100, cp[1]=0xAB -> next cycle rem SQUASH/0010, rem_target=0x100, rem_cp=0xAB, cur_b_mask=0001.
- SQUASH of 0001 with alloc_en=1 the same cycle -> allocation dropped; cur_b_mask=0000 the next cycle; one-cycle broadcast.
- After squash of 0010 freed 0100, a late SQUASH on 0100 -> no broadcast (rem_br_task stays NOTHING); state unchanged.
- Assert reset during an active SQUASH broadcast -> rem_br_task=NOTHING and cur_b_mask=0 without waiting for a clock edge.
